// File: rtl/nokia5110_ctrl_if.sv
// nokia5110_ctrl_if
//   Bundles the byte-level link between the Nokia 5110 sequencer and its two
//   neighbours: the spi_master (start/avail handshake, byte, dc, divider) and
//   the synchronous frame-buffer RAM (address out, data back one clk later).
//
//   Signals
//     spi_avail  spi_master idle / last byte finished
//     spi_start  one-cycle byte request to spi_master
//     spi_data   byte for spi_master data_in
//     spi_cmd    dc line: 0 = command, 1 = display RAM data
//     spi_div    spi_master clock divider constant
//     fb_addr    frame-buffer read address, 0..503
//     fb_data    frame-buffer byte, valid 1 clk after fb_addr
//
//   Modports
//     master  the sequencer (drives start/data/cmd/div/addr)
//     slave   the spi_master + frame-buffer side
interface nokia5110_ctrl_if;
    logic        spi_avail;
    logic        spi_start;
    logic [7:0]  spi_data;
    logic        spi_cmd;
    logic [15:0] spi_div;
    logic [8:0]  fb_addr;
    logic [7:0]  fb_data;

    modport master (
        input  spi_avail, fb_data,
        output spi_start, spi_data, spi_cmd, spi_div, fb_addr
    );

    modport slave (
        output spi_avail, fb_data,
        input  spi_start, spi_data, spi_cmd, spi_div, fb_addr
    );
endinterface

// File: rtl/nokia5110_ctrl.sv
// nokia5110_ctrl
//   Upstream sequencer for spi_master driving a Nokia 5110 (PCD8544) LCD.
//   After reset it sends the LCD init command sequence, then on each refresh
//   request it sends the X/Y home header and streams the 504-byte frame buffer
//   (84x48, 6 banks) as display data, one byte per start/avail handshake.
//
//   Parameters
//     VOP           contrast command byte (bit7 set), sent in extended mode
//     TEMP_COEF     temperature coefficient, sent as 8'h04 | TEMP_COEF
//     BIAS          bias system, sent as 8'h10 | BIAS
//     SPI_DIV       constant driven onto spi_div
//     AUTO_REFRESH  1: start a new frame whenever idle, no refresh needed
//
//   Ports
//     clk         system clock
//     reset       asynchronous reset, active high
//     refresh     one-cycle request to redraw the full frame
//     invert      (NK_INVERT_EN only) display inversion, sampled on idle exit
//     init_done   high once the init sequence has completed
//     busy        high in every state except IDLE
//     frame_done  one-cycle pulse after the last data byte of a frame
//     bus         spi_master / frame-buffer link (master modport)
//
//   Build option
//     NK_INVERT_EN  when defined, adds the invert input and prefixes every
//                   frame header with 8'h0C (normal) or 8'h0D (inverted).
module nokia5110_ctrl #(
    parameter logic [7:0]  VOP          = 8'hB8,
    parameter logic [1:0]  TEMP_COEF    = 2'd0,
    parameter logic [2:0]  BIAS         = 3'd4,
    parameter logic [15:0] SPI_DIV      = 16'd25,
    parameter bit          AUTO_REFRESH = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refresh,
`ifdef NK_INVERT_EN
    input  logic             invert,
`endif
    output logic             init_done,
    output logic             busy,
    output logic             frame_done,
    nokia5110_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_INIT,
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_DATA
    } state_t;

    // Per-byte handshake phase, shared by every state that sends a byte.
    typedef enum logic [1:0] {
        PH_SEND,
        PH_ACK,
        PH_DONE
    } phase_t;

`ifdef NK_INVERT_EN
    localparam logic [1:0] HDR_LAST = 2'd2;
`else
    localparam logic [1:0] HDR_LAST = 2'd1;
`endif
    localparam logic [2:0] INIT_LAST = 3'd5;
    localparam logic [8:0] FB_LAST   = 9'd503;

    state_t     state;
    phase_t     phase;
    logic [2:0] init_idx;
    logic [1:0] hdr_idx;
    logic [8:0] fb_addr;
    logic       pending;
    logic       spi_start_q;
    logic [7:0] spi_data_q;
    logic       spi_cmd_q;
`ifdef NK_INVERT_EN
    logic       invert_q;
`endif

    logic [7:0] init_byte;
    logic [7:0] hdr_byte;
    logic [7:0] tx_byte;
    logic       tx_cmd;
    logic       sending;
    logic       byte_done;

    assign bus.spi_start = spi_start_q;
    assign bus.spi_data  = spi_data_q;
    assign bus.spi_cmd   = spi_cmd_q;
    assign bus.spi_div   = SPI_DIV;
    assign bus.fb_addr   = fb_addr;

    // A byte only counts as finished once the master has gone busy (ACK)
    // and come back idle (DONE); this keeps long avail-low periods from
    // being mistaken for completion or triggering a second start.
    assign sending   = (state == ST_INIT) || (state == ST_HDR) || (state == ST_DATA);
    assign byte_done = sending && (phase == PH_DONE) && bus.spi_avail;

    // Init command table: function set (extended), Vop, temp coefficient,
    // bias, function set (basic), display control normal.
    always_comb begin
        init_byte = 8'h0C;
        case (init_idx)
            3'd0:    init_byte = 8'h21;
            3'd1:    init_byte = VOP;
            3'd2:    init_byte = 8'h04 | {6'd0, TEMP_COEF};
            3'd3:    init_byte = 8'h10 | {5'd0, BIAS};
            3'd4:    init_byte = 8'h20;
            default: init_byte = 8'h0C;
        endcase
    end

    // Frame header: home the RAM pointer to X=0, Y=0 before streaming data.
    // With inversion enabled, the display-control byte goes first so the
    // whole frame is drawn in the requested polarity.
    always_comb begin
        hdr_byte = 8'h40;
`ifdef NK_INVERT_EN
        case (hdr_idx)
            2'd0:    hdr_byte = {7'b0000110, invert_q};
            2'd1:    hdr_byte = 8'h80;
            default: hdr_byte = 8'h40;
        endcase
`else
        hdr_byte = (hdr_idx == 2'd0) ? 8'h80 : 8'h40;
`endif
    end

    // Selects the byte and dc value for whichever state is currently sending.
    always_comb begin
        tx_byte = 8'h00;
        tx_cmd  = 1'b0;
        case (state)
            ST_INIT: tx_byte = init_byte;
            ST_HDR:  tx_byte = hdr_byte;
            ST_DATA: begin
                tx_byte = bus.fb_data;
                tx_cmd  = 1'b1;
            end
            default: begin
                tx_byte = 8'h00;
                tx_cmd  = 1'b0;
            end
        endcase
    end

    // Main sequencer. The handshake phase runs underneath the top-level
    // state; the state only advances on byte_done. spi_data/spi_cmd are
    // loaded together with spi_start and then held until the next byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_BOOT;
            phase       <= PH_SEND;
            init_idx    <= 3'd0;
            hdr_idx     <= 2'd0;
            fb_addr     <= 9'd0;
            pending     <= 1'b0;
            spi_start_q <= 1'b0;
            spi_data_q  <= 8'h00;
            spi_cmd_q   <= 1'b0;
            init_done   <= 1'b0;
            busy        <= 1'b1;
            frame_done  <= 1'b0;
`ifdef NK_INVERT_EN
            invert_q    <= 1'b0;
`endif
        end else begin
            spi_start_q <= 1'b0;
            frame_done  <= 1'b0;

            // Requests that arrive while not idle are remembered (one deep);
            // in IDLE the request itself starts the frame instead.
            if (refresh && (state != ST_IDLE)) begin
                pending <= 1'b1;
            end

            if (sending) begin
                case (phase)
                    PH_SEND: begin
                        if (bus.spi_avail) begin
                            spi_start_q <= 1'b1;
                            spi_data_q  <= tx_byte;
                            spi_cmd_q   <= tx_cmd;
                            phase       <= PH_ACK;
                        end
                    end
                    PH_ACK: begin
                        if (!bus.spi_avail) begin
                            phase <= PH_DONE;
                        end
                    end
                    default: begin
                        if (bus.spi_avail) begin
                            phase <= PH_SEND;
                        end
                    end
                endcase
            end

            case (state)
                ST_BOOT: begin
                    if (bus.spi_avail) begin
                        state    <= ST_INIT;
                        init_idx <= 3'd0;
                    end
                end
                ST_INIT: begin
                    if (byte_done) begin
                        if (init_idx == INIT_LAST) begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            init_idx <= init_idx + 3'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (refresh || pending || AUTO_REFRESH) begin
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        hdr_idx <= 2'd0;
                        state   <= ST_HDR;
`ifdef NK_INVERT_EN
                        invert_q <= invert;
`endif
                    end
                end
                ST_HDR: begin
                    if (byte_done) begin
                        if (hdr_idx == HDR_LAST) begin
                            state <= ST_FETCH;
                        end else begin
                            hdr_idx <= hdr_idx + 2'd1;
                        end
                    end
                end
                ST_FETCH: begin
                    state <= ST_DATA;
                end
                ST_DATA: begin
                    if (byte_done) begin
                        if (fb_addr == FB_LAST) begin
                            fb_addr    <= 9'd0;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            fb_addr <= fb_addr + 9'd1;
                            state   <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nokia5110_ctrl.sv
// tb_nokia5110_ctrl
//   Self-checking bench for nokia5110_ctrl. A responder process models the
//   spi_master (random busy time per byte, a post-reset dummy shift, one very
//   long byte) and the synchronous frame-buffer RAM filled with random bytes.
//   Every byte launched by spi_start is logged and compared against a stream
//   built directly from the LCD protocol: init list, header, then the RAM.
module tb_nokia5110_ctrl;

    localparam int BOOT_DELAY = 20;
    localparam int LONG_HOLD  = 300;
    localparam int WAIT_LIMIT = 40000;

    logic clk = 1'b0;
    logic reset;
    logic refresh;
`ifdef NK_INVERT_EN
    logic invert;
`endif
    logic init_done;
    logic busy;
    logic frame_done;

    nokia5110_ctrl_if bus ();

    always #5 clk = ~clk;

    nokia5110_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .refresh    (refresh),
`ifdef NK_INVERT_EN
        .invert     (invert),
`endif
        .init_done  (init_done),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fb_mem [0:503];
    logic [8:0] sent_q [$];
    logic [8:0] exp_q  [$];

    int  hold_cnt;
    int  last_addr;
    int  frame_pulses;
    int  back_to_back;
    int  start_while_busy;
    int  data_in_frame;
    bit  prev_frame_done;
    bit  stretch_armed;
    bit  stretch_done;

    // Responder: frame-buffer RAM, byte logger and spi_master model, all
    // evaluated 1 time unit after each rising edge with blocking updates.
    initial begin
        bus.spi_avail    = 1'b0;
        bus.fb_data      = 8'h00;
        hold_cnt         = BOOT_DELAY;
        last_addr        = 0;
        frame_pulses     = 0;
        back_to_back     = 0;
        start_while_busy = 0;
        data_in_frame    = 0;
        prev_frame_done  = 1'b0;
        stretch_armed    = 1'b0;
        stretch_done     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.fb_data = (last_addr < 504) ? fb_mem[last_addr] : 8'hXX;
            last_addr   = int'(bus.fb_addr);

            if (frame_done) frame_pulses++;
            if (prev_frame_done && busy) back_to_back++;
            prev_frame_done = frame_done;

            if (bus.spi_start) begin
                if (!bus.spi_avail) start_while_busy++;
                sent_q.push_back({bus.spi_cmd, bus.spi_data});
            end

            if (reset) begin
                bus.spi_avail = 1'b0;
                hold_cnt      = BOOT_DELAY;
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) bus.spi_avail = 1'b1;
            end else if (bus.spi_start) begin
                bus.spi_avail = 1'b0;
                hold_cnt      = $urandom_range(1, 30);
                if (!bus.spi_cmd) begin
                    data_in_frame = 0;
                end else begin
                    if (stretch_armed && data_in_frame == 100) begin
                        hold_cnt      = LONG_HOLD;
                        stretch_armed = 1'b0;
                        stretch_done  = 1'b1;
                    end
                    data_in_frame++;
                end
            end
        end
    end

    initial begin
        #950000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One-cycle refresh pulse, driven away from the active edge.
    task automatic applyStimulus();
        @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    task automatic fill_fb();
        for (int i = 0; i < 504; i++) fb_mem[i] = 8'($urandom);
    endtask

    // Reference streams straight from the LCD command set.
    task automatic add_init();
        exp_q.push_back(9'h021);
        exp_q.push_back(9'h0B8);
        exp_q.push_back(9'h004);
        exp_q.push_back(9'h014);
        exp_q.push_back(9'h020);
        exp_q.push_back(9'h00C);
    endtask

    task automatic add_frame();
`ifdef NK_INVERT_EN
        exp_q.push_back(invert ? 9'h00D : 9'h00C);
`endif
        exp_q.push_back(9'h080);
        exp_q.push_back(9'h040);
        for (int i = 0; i < 504; i++) exp_q.push_back({1'b1, fb_mem[i]});
    endtask

    task automatic compare_stream(input string tag);
        checkOutput({tag, " byte count"}, 32'(sent_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
            checkOutput($sformatf("%s byte %0d", tag, i), 32'(sent_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, " spi_start"},  32'(bus.spi_start), 32'd0);
        checkOutput({tag, " spi_data"},   32'(bus.spi_data),  32'd0);
        checkOutput({tag, " spi_cmd"},    32'(bus.spi_cmd),   32'd0);
        checkOutput({tag, " fb_addr"},    32'(bus.fb_addr),   32'd0);
        checkOutput({tag, " init_done"},  32'(init_done),     32'd0);
        checkOutput({tag, " busy"},       32'(busy),          32'd1);
        checkOutput({tag, " frame_done"}, 32'(frame_done),    32'd0);
    endtask

    task automatic wait_init_done(input string tag);
        int n = 0;
        while (!init_done && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " init_done timeout"}, 32'(init_done), 32'd1);
    endtask

    task automatic wait_frames(input string tag, input int target);
        int n = 0;
        while (frame_pulses < target && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " frame_done timeout"}, 32'(frame_pulses >= target), 32'd1);
    endtask

    task automatic wait_data_bytes(input string tag, input int count);
        int n = 0;
        while (data_in_frame < count && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " data byte timeout"}, 32'(data_in_frame >= count), 32'd1);
    endtask

    initial begin
        int gap;
        reset   = 1'b1;
        refresh = 1'b0;
`ifdef NK_INVERT_EN
        invert  = 1'b0;
`endif
        fill_fb();

        // Reset state and constant divider.
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        checkOutput("spi_div", 32'(bus.spi_div), 32'd25);

        // Init sequence after reset, with the master's dummy shift first.
        reset = 1'b0;
        wait_init_done("init");
        checkOutput("init busy low", 32'(busy), 32'd0);
        checkOutput("init after last done", 32'(bus.spi_avail), 32'd1);
        exp_q.delete();
        add_init();
        compare_stream("init");

        // Frame 1 with two extra refreshes merging into exactly one more
        // frame; data byte 100 is held busy for a long time by the master.
        sent_q.delete();
        exp_q.delete();
        frame_pulses  = 0;
        back_to_back  = 0;
        stretch_armed = 1'b1;
`ifdef NK_INVERT_EN
        invert = 1'($urandom_range(0, 1));
`endif
        applyStimulus();
        wait_data_bytes("frame1", 50 + $urandom_range(0, 100));
        applyStimulus();
        gap = $urandom_range(1, 500);
        repeat (gap) @(negedge clk);
        applyStimulus();
        wait_frames("frames", 2);
        repeat (200) @(negedge clk);
        add_frame();
        add_frame();
        compare_stream("frames");
        checkOutput("frame_done pulses", 32'(frame_pulses), 32'd2);
        checkOutput("pending starts next clk", 32'(back_to_back), 32'd1);
        checkOutput("idle busy", 32'(busy), 32'd0);
        checkOutput("idle fb_addr", 32'(bus.fb_addr), 32'd0);
        checkOutput("long hold reached", 32'(stretch_done), 32'd1);
        checkOutput("start while master busy", 32'(start_while_busy), 32'd0);

        // Reset in the middle of a frame, then refresh during init.
        sent_q.delete();
        applyStimulus();
        wait_data_bytes("partial", 201);
        repeat ($urandom_range(0, 10)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("mid reset");
        repeat (3) @(negedge clk);
        sent_q.delete();
        exp_q.delete();
        frame_pulses = 0;
        fill_fb();
`ifdef NK_INVERT_EN
        invert = ~invert;
`endif
        reset = 1'b0;
        begin
            int n = 0;
            while (sent_q.size() < 2 && n < WAIT_LIMIT) begin
                @(negedge clk);
                n++;
            end
            checkOutput("reinit start timeout", 32'(sent_q.size() >= 2), 32'd1);
        end
        applyStimulus();
        wait_init_done("reinit");
        wait_frames("pending frame", 1);
        repeat (100) @(negedge clk);
        add_init();
        add_frame();
        compare_stream("reinit+frame");
        checkOutput("final frame_done pulses", 32'(frame_pulses), 32'd1);
        checkOutput("final busy", 32'(busy), 32'd0);
        checkOutput("final start while master busy", 32'(start_while_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
